gate_test_sequencer: RTL and testbench
======================================

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, meaning: clocks each input vector is held before the gate outputs are sampled; legal range 1..15.
REQ-002 Clocking is fixed: one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request a test run; sampled only in IDLE.
REQ-006 Port: a  output  1  gate operand A, registered.
REQ-007 Port: b  output  1  gate operand B, registered.
REQ-008 Ports: and_in, or_in, not_in, nand_in, nor_in, xor_in  input  1 each  outputs returned from the six gates under test (NOT gate driven by a only).
REQ-009 Port: busy  output  1  high while a run is in progress.
REQ-010 Port: done  output  1  one-clock pulse at run completion.
REQ-011 Port: pass  output  1  1 when the last completed run had zero mismatches.
REQ-012 Port: err_count  output  3  number of failing vectors in the last or current run (0..4).
REQ-013 Port: fail_mask  output  4  bit i set when vector i failed.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-015 Vector index i (2 bits) SHALL drive a=i[1] and b=i[0], in the order 00, 01, 10, 11.
REQ-016 IDLE with start=1 at an edge: clear err_count and fail_mask, set i=0, drive a=0 and b=0, clear the settle counter, go to SETTLE, busy=1.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES clocks and then go to SAMPLE; a and b SHALL stay stable throughout.
REQ-018 SAMPLE (one clock) SHALL compare the six inputs against expected values computed from the registered a and b: and=a&b, or=a|b, not=~a, nand=~(a&b), nor=~(a|b), xor=a^b.
REQ-019 Any mismatch in SAMPLE: set fail_mask[i] and increment err_count by exactly 1, regardless of how many of the six outputs differ.
REQ-020 SAMPLE with i<3: increment i, update a and b on the same edge, go to SETTLE; with i=3: go to DONE.
REQ-021 DONE (one clock): done=1, busy=0, pass=(err_count==0 including the final vector's result); go to IDLE.
REQ-022 pass, err_count, and fail_mask SHALL hold their values until the next accepted start; pass SHALL clear to 0 when a start is accepted.
REQ-023 start SHALL be ignored in SETTLE, SAMPLE, and DONE; a start held high SHALL begin a new run on the first IDLE edge after DONE.
REQ-024 Latency: done SHALL assert in the 4*(SETTLE_CYCLES+1)+1-th clock after the start-accepting edge (13th at default).
REQ-025 In IDLE, a and b SHALL hold their last driven values.

Reset
REQ-026 When rst=1 the block SHALL immediately, without a clock, set state=IDLE and drive a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, i=0, settle counter=0.
REQ-027 Reset mid-run SHALL abort the run with no done pulse; the first start after rst deasserts SHALL begin a clean run.

Verification
REQ-028 All gates correct, start pulsed -> a,b sequence 00, 01, 10, 11, each held 3 clocks; done at clock 13; pass=1, err_count=0, fail_mask=0000.
REQ-029 xor_in tied to 0 -> vectors 01 and 10 fail; fail_mask=0110, err_count=2, pass=0.
REQ-030 not_in wired to a (inverted) -> every vector fails; fail_mask=1111, err_count=4, pass=0.
REQ-031 rst asserted while i=2 -> all outputs 0 asynchronously, no done pulse; re-start -> full run passes.
REQ-032 start held high continuously -> back-to-back runs with exactly one IDLE clock between DONE and the next SETTLE; extra start pulses during busy have no effect.
REQ-033 SETTLE_CYCLES=1 -> each vector held 2 clocks; done at clock 9.

Source files
------------

// File: rtl/gate_test_sequencer.sv
// Drives the four operand combinations into six external logic gates, waits for
// them to settle, compares each returned output and reports a pass/fail summary.
module gate_test_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       and_in,
    input  logic       or_in,
    input  logic       not_in,
    input  logic       nand_in,
    input  logic       nor_in,
    input  logic       xor_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    // Golden response ordered {and, or, not, nand, nor, xor}; NOT sees only a.
    function automatic logic [5:0] gate_expect(input logic op_a, input logic op_b);
        gate_expect = {op_a & op_b, op_a | op_b, ~op_a,
                       ~(op_a & op_b), ~(op_a | op_b), op_a ^ op_b};
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  vec_q, vec_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        a_q, a_d;
    logic        b_q, b_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [2:0]  err_q, err_d;
    logic [3:0]  mask_q, mask_d;
    logic [5:0]  observed_s;
    logic        mismatch_s;

    assign observed_s = {and_in, or_in, not_in, nand_in, nor_in, xor_in};
    assign mismatch_s = |(observed_s ^ gate_expect(a_q, b_q));

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            mask_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        mask_d  = mask_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    vec_d   = 2'd0;
                    cnt_d   = 4'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = 3'd0;
                    mask_d  = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                // A vector counts once no matter how many gates disagree.
                if (mismatch_s) begin
                    mask_d[vec_q] = 1'b1;
                    err_d         = err_q + 3'd1;
                end else begin
                    err_d         = err_q;
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    a_d     = vec_d[1];
                    b_d     = vec_d[0];
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_d == 3'd0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench: behavioural gate models with injectable faults around two
// sequencer instances (default settle time and a one-cycle settle time).
module tb_gate_test_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic xor_zero;
    logic not_bad;
    logic sel;

    always #5 clk = ~clk;

    logic       a0, b0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] mask0;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] mask1;

    gate_test_sequencer dut0 (
        .clk(clk), .rst(rst), .start(start), .a(a0), .b(b0),
        .and_in(a0 & b0), .or_in(a0 | b0),
        .not_in(not_bad ? a0 : ~a0),
        .nand_in(~(a0 & b0)), .nor_in(~(a0 | b0)),
        .xor_in(xor_zero ? 1'b0 : (a0 ^ b0)),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_mask(mask0)
    );

    gate_test_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a1), .b(b1),
        .and_in(a1 & b1), .or_in(a1 | b1),
        .not_in(not_bad ? a1 : ~a1),
        .nand_in(~(a1 & b1)), .nor_in(~(a1 | b1)),
        .xor_in(xor_zero ? 1'b0 : (a1 ^ b1)),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(mask1)
    );

    logic       oa, ob, obusy, odone, opass;
    logic [2:0] oerr;
    logic [3:0] omask;
    assign oa    = sel ? a1    : a0;
    assign ob    = sel ? b1    : b0;
    assign obusy = sel ? busy1 : busy0;
    assign odone = sel ? done1 : done0;
    assign opass = sel ? pass1 : pass0;
    assign oerr  = sel ? err1  : err0;
    assign omask = sel ? mask1 : mask0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ab"},   {6'd0, oa, ob}, 8'd0);
        chk({tag, "_busy"}, {7'd0, obusy},  8'd0);
        chk({tag, "_done"}, {7'd0, odone},  8'd0);
        chk({tag, "_pass"}, {7'd0, opass},  8'd0);
        chk({tag, "_err"},  {5'd0, oerr},   8'd0);
        chk({tag, "_mask"}, {4'd0, omask},  8'd0);
    endtask

    // Caller raises start at a negedge; this consumes the accepting edge and the whole run.
    task automatic run_check(input int s, input bit keep, input logic [3:0] m,
                             input logic [2:0] e, input logic p);
        int last;
        int idx;
        last = 4 * (s + 1) + 1;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            start = keep;
            idx = (c - 1) / (s + 1);
            if (idx > 3) idx = 3;
            chk("run_ab",   {6'd0, oa, ob},  8'(idx));
            chk("run_busy", {7'd0, obusy},   {7'd0, (c < last)});
            chk("run_done", {7'd0, odone},   {7'd0, (c == last)});
            if (c == 1) begin
                chk("run_clr_pass", {7'd0, opass}, 8'd0);
                chk("run_clr_err",  {5'd0, oerr},  8'd0);
                chk("run_clr_mask", {4'd0, omask}, 8'd0);
            end
        end
        chk("end_pass", {7'd0, opass}, {7'd0, p});
        chk("end_err",  {5'd0, oerr},  {5'd0, e});
        chk("end_mask", {4'd0, omask}, {4'd0, m});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; xor_zero = 1'b0; not_bad = 1'b0; sel = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // All gates good: full pass, results then held in IDLE.
        start = 1'b1;
        run_check(2, 1'b0, 4'b0000, 3'd0, 1'b1);
        repeat (2) @(negedge clk);
        chk("idle_ab",   {6'd0, oa, ob}, 8'd3);
        chk("idle_busy", {7'd0, obusy},  8'd0);
        chk("idle_pass", {7'd0, opass},  8'd1);

        // XOR stuck at zero: vectors 01 and 10 fail.
        xor_zero = 1'b1;
        start = 1'b1;
        run_check(2, 1'b0, 4'b0110, 3'd2, 1'b0);
        xor_zero = 1'b0;
        @(negedge clk);

        // NOT gate non-inverting: every vector fails.
        not_bad = 1'b1;
        start = 1'b1;
        run_check(2, 1'b0, 4'b1111, 3'd4, 1'b0);
        not_bad = 1'b0;
        @(negedge clk);
        chk("hold_err", {5'd0, oerr}, 8'd4);

        // Reset while vector 2 is applied: immediate clear, no done pulse.
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_ab", {6'd0, oa, ob}, 8'd2);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        repeat (2) begin
            @(negedge clk);
            chk("rst_done", {7'd0, odone}, 8'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", {7'd0, odone}, 8'd0);
            chk("post_rst_busy", {7'd0, obusy}, 8'd0);
        end
        start = 1'b1;
        run_check(2, 1'b0, 4'b0000, 3'd0, 1'b1);

        // Start held high: back-to-back runs with one IDLE clock between them.
        @(negedge clk);
        start = 1'b1;
        run_check(2, 1'b1, 4'b0000, 3'd0, 1'b1);
        @(negedge clk);
        chk("gap_busy", {7'd0, obusy},  8'd0);
        chk("gap_done", {7'd0, odone},  8'd0);
        chk("gap_ab",   {6'd0, oa, ob}, 8'd3);
        run_check(2, 1'b0, 4'b0000, 3'd0, 1'b1);

        // One-cycle settle instance: done in clock 9.
        repeat (20) @(negedge clk);
        sel = 1'b1;
        start = 1'b1;
        run_check(1, 1'b0, 4'b0000, 3'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
